spi_xfer_sched: RTL and testbench

Transfer scheduler sitting in front of `spi_shift`. Arbitrates round-robin between `NREQ` local requesters, loads the winner's transmit word into the shifter, and drives the slave selects and the `go` sequence. It waits for the shifter to finish, then returns the received word to the winner with a one-cycle completion strobe. It is the only block that drives the `spi_shift` control inputs.

---
 rtl/spi_xfer_sched_pkg.sv | 23 ++
 rtl/spi_rr_arb.sv | 31 +++
 rtl/spi_xfer_sched.sv | 200 ++++++++++++++++++++
 tb/tb_spi_xfer_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_sched_pkg.sv
// Shared constants for the SPI transfer scheduler: state encoding, default
// sizing and the LOAD-phase latch decoder.
package spi_xfer_sched_pkg;

  localparam int SPI_MAX_CHAR      = 128;
  localparam int SPI_CHAR_LEN_BITS = 7;
  localparam int SPI_SCHED_NREQ    = 4;
  localparam int SPI_SCHED_GAP     = 2;

  localparam logic [2:0] SPI_SCHED_IDLE  = 3'd0;
  localparam logic [2:0] SPI_SCHED_LOAD  = 3'd1;
  localparam logic [2:0] SPI_SCHED_START = 3'd2;
  localparam logic [2:0] SPI_SCHED_RUN   = 3'd3;
  localparam logic [2:0] SPI_SCHED_DONE  = 3'd4;
  localparam logic [2:0] SPI_SCHED_GAP_S = 3'd5;
  localparam logic [2:0] SPI_SCHED_ABORT = 3'd6;

  // The shifter has four 32-bit latch lanes, so wider words reuse them cyclically.
  function automatic logic [3:0] latch_bit(input int k);
    latch_bit = 4'b0001 << (k % 4);
  endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around, reported both one-hot and as an index.
module spi_rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Round-robin transfer scheduler in front of spi_shift: loads the winner's
// word, runs the go/tip handshake and returns the received word.
module spi_xfer_sched
  import spi_xfer_sched_pkg::*;
#(
  parameter int NREQ    = SPI_SCHED_NREQ,
  parameter int DW      = SPI_MAX_CHAR,
  parameter int LW      = SPI_CHAR_LEN_BITS,
  parameter int SS_NB   = 8,
  parameter int GAP_CYC = SPI_SCHED_GAP,
  parameter int TIMEOUT = 1023
) (
  input  logic                  wb_clk,
  input  logic                  wb_reset,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*DW-1:0]    req_data_i,
  input  logic [NREQ*LW-1:0]    req_len_i,
  input  logic [NREQ*SS_NB-1:0] req_ss_i,
  input  logic [NREQ-1:0]       req_lsb_i,
  input  logic [NREQ-1:0]       req_rxneg_i,
  input  logic [NREQ-1:0]       req_txneg_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic [NREQ-1:0]       err_o,
  output logic [DW-1:0]         rsp_data_o,
  output logic                  busy_o,
  output logic                  go,
  output logic                  lsb,
  output logic                  rx_negedge,
  output logic                  tx_negedge,
  output logic [LW-1:0]         len,
  output logic [3:0]            latch,
  output logic [3:0]            byte_sel,
  output logic [31:0]           p_in,
  input  logic                  tip,
  input  logic                  last,
  input  logic [DW-1:0]         p_out,
  output logic [SS_NB-1:0]      ss_pad_o
);

  localparam int NW = DW / 32;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [2:0]      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt_idx;
  logic [KW-1:0]   word_idx;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gap_cnt;

  logic [DW-1:0]    data_arr [NREQ];
  logic [LW-1:0]    len_arr  [NREQ];
  logic [SS_NB-1:0] ss_arr   [NREQ];

  for (genvar r = 0; r < NREQ; r++) begin : g_slice
    assign data_arr[r] = req_data_i[r*DW +: DW];
    assign len_arr[r]  = req_len_i[r*LW +: LW];
    assign ss_arr[r]   = req_ss_i[r*SS_NB +: SS_NB];
  end

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;

  spi_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Word about to be presented: word 0 of the arbitration winner while idle,
  // otherwise the next word of the granted requester.
  logic [KW-1:0] word_nxt;
  logic [PW-1:0] sel_idx;
  logic [31:0]   word_nxt_data;
  logic [PW-1:0] ptr_nxt;

  always_comb begin
    word_nxt      = (state == SPI_SCHED_IDLE) ? '0 : word_idx + KW'(1);
    sel_idx       = (state == SPI_SCHED_IDLE) ? arb_idx : gnt_idx;
    word_nxt_data = data_arr[sel_idx][32*int'(word_nxt) +: 32];
    ptr_nxt       = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
  end

  logic unused_last;
  assign unused_last = last;

  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      state      <= SPI_SCHED_IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      word_idx   <= '0;
      tcnt       <= '0;
      gap_cnt    <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      err_o      <= '0;
      rsp_data_o <= '0;
      busy_o     <= 1'b0;
      go         <= 1'b0;
      lsb        <= 1'b0;
      rx_negedge <= 1'b0;
      tx_negedge <= 1'b0;
      len        <= '0;
      latch      <= '0;
      byte_sel   <= '0;
      p_in       <= '0;
      ss_pad_o   <= '1;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state)
        SPI_SCHED_IDLE: begin
          if (arb_any) begin
            state      <= SPI_SCHED_LOAD;
            busy_o     <= 1'b1;
            gnt_o      <= arb_gnt;
            gnt_idx    <= arb_idx;
            word_idx   <= '0;
            latch      <= latch_bit(0);
            byte_sel   <= 4'hF;
            p_in       <= word_nxt_data;
            len        <= len_arr[arb_idx];
            lsb        <= req_lsb_i[arb_idx];
            rx_negedge <= req_rxneg_i[arb_idx];
            tx_negedge <= req_txneg_i[arb_idx];
            ss_pad_o   <= ~ss_arr[arb_idx];
          end
        end
        SPI_SCHED_LOAD: begin
          if (word_idx == KW'(NW - 1)) begin
            state    <= SPI_SCHED_START;
            latch    <= '0;
            byte_sel <= '0;
            p_in     <= '0;
            go       <= 1'b1;
            tcnt     <= '0;
          end else begin
            word_idx <= word_nxt;
            latch    <= latch_bit(int'(word_nxt));
            p_in     <= word_nxt_data;
          end
        end
        SPI_SCHED_START: begin
          if (tip) begin
            state <= SPI_SCHED_RUN;
          end else if (tcnt == TW'(TIMEOUT)) begin
            state <= SPI_SCHED_ABORT;
            go    <= 1'b0;
            err_o <= gnt_o;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        SPI_SCHED_RUN: begin
          if (!tip) begin
            state      <= SPI_SCHED_DONE;
            go         <= 1'b0;
            rsp_data_o <= p_out;
            done_o     <= gnt_o;
          end
        end
        SPI_SCHED_DONE, SPI_SCHED_ABORT: begin
          state      <= SPI_SCHED_GAP_S;
          gnt_o      <= '0;
          ss_pad_o   <= '1;
          len        <= '0;
          lsb        <= 1'b0;
          rx_negedge <= 1'b0;
          tx_negedge <= 1'b0;
          rsp_data_o <= '0;
          ptr        <= ptr_nxt;
          gap_cnt    <= '0;
        end
        SPI_SCHED_GAP_S: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            state  <= SPI_SCHED_IDLE;
            busy_o <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state    <= SPI_SCHED_IDLE;
          busy_o   <= 1'b0;
          gnt_o    <= '0;
          go       <= 1'b0;
          ss_pad_o <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Scoreboard bench for spi_xfer_sched with a behavioural spi_shift responder;
// completions are checked against expectations queued when requests are made.
`timescale 1ns/1ps
module tb_spi_xfer_sched;

  localparam int NREQ = 4, DW = 128, LW = 7, SS_NB = 8, GAP_CYC = 2, TIMEOUT = 1023;

  logic                  wb_clk = 1'b0;
  logic                  wb_reset;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*DW-1:0]    req_data_i;
  logic [NREQ*LW-1:0]    req_len_i;
  logic [NREQ*SS_NB-1:0] req_ss_i;
  logic [NREQ-1:0]       req_lsb_i, req_rxneg_i, req_txneg_i;
  logic [NREQ-1:0]       gnt_o, done_o, err_o;
  logic [DW-1:0]         rsp_data_o;
  logic                  busy_o, go, lsb, rx_negedge, tx_negedge;
  logic [LW-1:0]         len;
  logic [3:0]            latch, byte_sel;
  logic [31:0]           p_in;
  logic                  tip, last;
  logic [DW-1:0]         p_out;
  logic [SS_NB-1:0]      ss_pad_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            r;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sb[$];

  int xfer_n = 0;
  bit shifter_en = 1'b1;
  int sh_st = 0;
  int sh_cnt = 0;

  always #5 wb_clk = ~wb_clk;

  spi_xfer_sched #(
    .NREQ(NREQ), .DW(DW), .LW(LW), .SS_NB(SS_NB), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk(wb_clk), .wb_reset(wb_reset), .req_i(req_i), .req_data_i(req_data_i),
    .req_len_i(req_len_i), .req_ss_i(req_ss_i), .req_lsb_i(req_lsb_i),
    .req_rxneg_i(req_rxneg_i), .req_txneg_i(req_txneg_i), .gnt_o(gnt_o),
    .done_o(done_o), .err_o(err_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o),
    .go(go), .lsb(lsb), .rx_negedge(rx_negedge), .tx_negedge(tx_negedge),
    .len(len), .latch(latch), .byte_sel(byte_sel), .p_in(p_in), .tip(tip),
    .last(last), .p_out(p_out), .ss_pad_o(ss_pad_o)
  );

  function automatic logic [DW-1:0] rsp_of(input int n);
    rsp_of = {4{32'h5A5A_0000 + 32'(n)}};
  endfunction

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_fields(input int r, input logic [DW-1:0] d, input logic [LW-1:0] l,
                            input logic [SS_NB-1:0] ss, input logic b);
    req_data_i[r*DW +: DW]    = d;
    req_len_i[r*LW +: LW]     = l;
    req_ss_i[r*SS_NB +: SS_NB] = ss;
    req_lsb_i[r]   = b;
    req_rxneg_i[r] = ~b;
    req_txneg_i[r] = b;
  endtask

  // Shifter model: answers go with tip high for three cycles, then waits for go to drop.
  initial begin
    tip = 1'b0; last = 1'b0; p_out = '0;
    forever begin
      tick();
      if (wb_reset || !shifter_en) begin
        tip = 1'b0; last = 1'b0; sh_st = 0;
      end else begin
        case (sh_st)
          0: if (go) begin
               tip = 1'b1; p_out = rsp_of(xfer_n); xfer_n++; sh_cnt = 3; sh_st = 1;
             end
          1: begin
               sh_cnt--;
               if (sh_cnt == 1) last = 1'b1;
               if (sh_cnt == 0) begin tip = 1'b0; last = 1'b0; sh_st = 2; end
             end
          2: if (!go) sh_st = 0;
          default: sh_st = 0;
        endcase
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge wb_clk);
      if (done_o !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_done got %b required none", done_o);
        end else begin
          e = sb.pop_front();
          if (done_o !== (4'b0001 << e.r)) begin
            errors++;
            $display("[TB] FAIL done_onehot got %b required %b", done_o, 4'b0001 << e.r);
          end
          checks++;
          if (rsp_data_o !== e.d) begin
            errors++;
            $display("[TB] FAIL rsp_data got %h required %h", rsp_data_o, e.d);
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int c = 0; c < 30 && busy_o; c++) tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle got busy %b required 0", name, busy_o);
    end
  endtask

  task automatic test_reset();
    wb_reset = 1'b1;
    tick();
    wb_reset = 1'b0;
    tick();
    checks++;
    if ({gnt_o, done_o, err_o, go, latch, byte_sel, p_in, len, lsb, rx_negedge, tx_negedge, busy_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_controls got gnt %b go %b latch %b p_in %h len %0d busy %b required all 0",
               gnt_o, go, latch, p_in, len, busy_o);
    end
    checks++;
    if (ss_pad_o !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL reset_ss got %h required ff", ss_pad_o);
    end
    checks++;
    if (rsp_data_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_rsp got %h required 0", rsp_data_o);
    end
  endtask

  task automatic test_single();
    int n;
    int go_low;
    set_fields(0, 128'hAA55, 7'd4, 8'h01, 1'b1);
    sb.push_back('{0, rsp_of(xfer_n)});
    req_i = 4'b0001;
    tick();
    checks++;
    if ({gnt_o, ss_pad_o, latch, byte_sel} !== {4'b0001, 8'hFE, 4'b0001, 4'hF}) begin
      errors++;
      $display("[TB] FAIL single_grant got gnt %b ss %h latch %b bsel %h required 0001 fe 0001 f",
               gnt_o, ss_pad_o, latch, byte_sel);
    end
    checks++;
    if ({p_in, len, lsb, rx_negedge, tx_negedge} !== {32'hAA55, 7'd4, 3'b101}) begin
      errors++;
      $display("[TB] FAIL single_word0 got p_in %h len %0d mode %b required aa55 4 101",
               p_in, len, {lsb, rx_negedge, tx_negedge});
    end
    tick();
    checks++;
    if ({latch, p_in} !== {4'b0010, 32'h0}) begin
      errors++;
      $display("[TB] FAIL single_word1 got latch %b p_in %h required 0010 0", latch, p_in);
    end
    tick(); tick(); tick();
    checks++;
    if ({go, latch} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL single_go_rise got go %b latch %b required 1 0000", go, latch);
    end
    n = 0; go_low = 0;
    while (done_o === '0 && n < 100) begin
      if (go !== 1'b1) go_low++;
      tick();
      n++;
    end
    checks++;
    if (n >= 100 || go_low != 0) begin
      errors++;
      $display("[TB] FAIL single_go_hold got cycles %0d go_low %0d required done within 100 go_low 0", n, go_low);
    end
    checks++;
    if ({go, ss_pad_o} !== {1'b0, 8'hFE}) begin
      errors++;
      $display("[TB] FAIL single_done_cycle got go %b ss %h required 0 fe", go, ss_pad_o);
    end
    req_i = '0;
    tick();
    checks++;
    if ({gnt_o, ss_pad_o} !== {4'b0000, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL single_release got gnt %b ss %h required 0000 ff", gnt_o, ss_pad_o);
    end
    wait_idle("single");
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] prev;
    int ones, ng, nd, base;
    wb_reset = 1'b1;
    tick();
    wb_reset = 1'b0;
    for (int r = 0; r < NREQ; r++)
      set_fields(r, {4{32'h1000_0000 * (r + 1) + 32'(r)}}, 7'(8 * (r + 1)), 8'(1 << r), r[0]);
    base = xfer_n;
    for (int i = 0; i < 5; i++) sb.push_back('{i % NREQ, rsp_of(base + i)});
    req_i = 4'b1111;
    prev = '0; ones = 0; ng = 0; nd = 0;
    for (int c = 0; c < 500 && nd < 5; c++) begin
      tick();
      if (gnt_o !== '0 && prev === '0) begin
        checks++;
        if (gnt_o !== (4'b0001 << (ng % NREQ))) begin
          errors++;
          $display("[TB] FAIL rr_order got %b required %b (grant %0d)", gnt_o, 4'b0001 << (ng % NREQ), ng);
        end
        if (ng > 0) begin
          checks++;
          if (ones != GAP_CYC + 1) begin
            errors++;
            $display("[TB] FAIL rr_gap got %0d required %0d", ones, GAP_CYC + 1);
          end
        end
        ng++;
      end
      ones = (ss_pad_o === 8'hFF) ? ones + 1 : 0;
      prev = gnt_o;
      if (done_o !== '0) begin
        nd++;
        if (nd == 5) req_i = '0;
      end
    end
    req_i = '0;
    checks++;
    if (nd != 5) begin
      errors++;
      $display("[TB] FAIL rr_timeout got %0d completions required 5", nd);
    end
    wait_idle("rr");
  endtask

  task automatic test_wrap();
    int n;
    sb.push_back('{3, rsp_of(xfer_n)});
    req_i = 4'b1000;
    n = 0;
    while (done_o === '0 && n < 100) begin tick(); n++; end
    req_i = '0;
    wait_idle("wrap_r3");
    sb.push_back('{0, rsp_of(xfer_n)});
    req_i = 4'b1001;
    n = 0;
    while (gnt_o === '0 && n < 20) begin tick(); n++; end
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL wrap_grant got %b required 0001", gnt_o);
    end
    n = 0;
    while (done_o === '0 && n < 100) begin tick(); n++; end
    req_i = '0;
    wait_idle("wrap_r0");
  endtask

  task automatic test_timeout();
    int n;
    shifter_en = 1'b0;
    req_i = 4'b0100;
    n = 0;
    while (go !== 1'b1 && n < 20) begin tick(); n++; end
    n = 0;
    while (err_o === '0 && n < TIMEOUT + 20) begin tick(); n++; end
    checks++;
    if (n != TIMEOUT + 1) begin
      errors++;
      $display("[TB] FAIL timeout_latency got %0d required %0d", n, TIMEOUT + 1);
    end
    checks++;
    if ({err_o, go} !== {4'b0100, 1'b0}) begin
      errors++;
      $display("[TB] FAIL timeout_err got err %b go %b required 0100 0", err_o, go);
    end
    req_i = '0;
    tick();
    checks++;
    if ({err_o, gnt_o, ss_pad_o} !== {4'b0000, 4'b0000, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL timeout_release got err %b gnt %b ss %h required 0000 0000 ff", err_o, gnt_o, ss_pad_o);
    end
    wait_idle("timeout");
    shifter_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    req_i = 4'b0010;
    n = 0;
    while (tip !== 1'b1 && n < 30) begin tick(); n++; end
    tick();
    checks++;
    if ({go, busy_o} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL rstmid_running got go %b busy %b required 1 1", go, busy_o);
    end
    wb_reset = 1'b1;
    #1;
    checks++;
    if ({ss_pad_o, go, gnt_o, busy_o} !== {8'hFF, 1'b0, 4'b0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rstmid_async got ss %h go %b gnt %b busy %b required ff 0 0000 0",
               ss_pad_o, go, gnt_o, busy_o);
    end
    tick();
    wb_reset = 1'b0;
    req_i = '0;
    tick();
    sb.push_back('{0, rsp_of(xfer_n)});
    req_i = 4'b0011;
    n = 0;
    while (gnt_o === '0 && n < 20) begin tick(); n++; end
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rstmid_regrant got %b required 0001", gnt_o);
    end
    n = 0;
    while (done_o === '0 && n < 100) begin tick(); n++; end
    req_i = '0;
    wait_idle("rstmid");
  endtask

  task automatic test_len0();
    logic [DW-1:0] d;
    logic [31:0]   w;
    int n;
    d = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    set_fields(3, d, 7'd0, 8'h80, 1'b0);
    sb.push_back('{3, rsp_of(xfer_n)});
    req_i = 4'b1000;
    tick();
    for (int k = 0; k < 4; k++) begin
      w = d[32*k +: 32];
      checks++;
      if ({latch, p_in, len, ss_pad_o} !== {4'b0001 << k, w, 7'd0, 8'h7F}) begin
        errors++;
        $display("[TB] FAIL len0_load%0d got latch %b p_in %h len %0d ss %h required %b %h 0 7f",
                 k, latch, p_in, len, ss_pad_o, 4'b0001 << k, w);
      end
      tick();
    end
    checks++;
    if ({go, latch} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL len0_go got go %b latch %b required 1 0000", go, latch);
    end
    n = 0;
    while (done_o === '0 && n < 100) begin tick(); n++; end
    req_i = '0;
    wait_idle("len0");
  endtask

  initial begin
    wb_reset = 1'b0;
    req_i = '0; req_data_i = '0; req_len_i = '0; req_ss_i = '0;
    req_lsb_i = '0; req_rxneg_i = '0; req_txneg_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_len0();
    tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
